rv_mem_arbiter: RTL and testbench

- Shares the single-port data/instruction RAM between two requesters.
  - Port 0: the core's fetch/load/store path, driven by the micro-sequencer.
  - Port 1: the boot loader / debug port.
- Serialises accesses through a small FSM and owns all RAM control signals (address, write data, write enable, output-register enable).
- Returns read data with a valid pulse that accounts for the RAM's registered-output latency.
- Sits between the core/loader and the RAM instance at the top level.

---
 rtl/rv_mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_rv_mem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM with registered output latency RD_LAT.
// Build option MEMARB_FIXED_PRIO_EN: port 1 always wins ties; otherwise round-robin.
module rv_mem_arbiter #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   output logic              ram_regce,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
);

   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

   state_t              r_state, w_state;
   logic                r_id, w_id;
   logic                r_we, w_we;
   logic [CNT_W-1:0]    r_cnt, w_cnt;
   logic                r_m0_gnt, w_m0_gnt, r_m1_gnt, w_m1_gnt;
   logic                r_m0_rvalid, w_m0_rvalid, r_m1_rvalid, w_m1_rvalid;
   logic [DATA_W-1:0]   r_m0_rdata, w_m0_rdata, r_m1_rdata, w_m1_rdata;
   logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr;
   logic [DATA_W-1:0]   r_ram_din, w_ram_din;
   logic                r_ram_we, w_ram_we, r_ram_regce, w_ram_regce;
   logic                r_busy, w_busy;
   logic                w_pick;

`ifdef MEMARB_FIXED_PRIO_EN
   assign w_pick = m1_req;
`else
   logic r_last, w_last;
   // Both requesting: the port that did not win last time gets it.
   assign w_pick = (m0_req & m1_req) ? ~r_last : m1_req;
`endif

   // Next-state and next-output logic; every output is registered from these.
   always_comb begin
      w_state     = r_state;
      w_id        = r_id;
      w_we        = r_we;
      w_cnt       = r_cnt;
      w_m0_gnt    = 1'b0;
      w_m1_gnt    = 1'b0;
      w_m0_rvalid = 1'b0;
      w_m1_rvalid = 1'b0;
      w_m0_rdata  = r_m0_rdata;
      w_m1_rdata  = r_m1_rdata;
      w_ram_addr  = r_ram_addr;
      w_ram_din   = r_ram_din;
      w_ram_we    = 1'b0;
      w_ram_regce = 1'b0;
`ifndef MEMARB_FIXED_PRIO_EN
      w_last      = r_last;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (m0_req | m1_req) begin
               w_state     = S_ACCESS;
               w_id        = w_pick;
               w_we        = w_pick ? m1_we : m0_we;
               w_ram_addr  = w_pick ? m1_addr : m0_addr;
               w_ram_din   = w_pick ? m1_wdata : m0_wdata;
               w_ram_we    = w_we;
               w_ram_regce = ~w_we;
               w_m0_gnt    = ~w_pick;
               w_m1_gnt    = w_pick;
`ifndef MEMARB_FIXED_PRIO_EN
               w_last      = w_pick;
`endif
            end
         end
         S_ACCESS: begin
            if (r_we) begin
               w_state = S_IDLE;
            end else if (RD_LAT == 1) begin
               w_state = S_RESP;
            end else begin
               w_state     = S_WAIT;
               w_cnt       = CNT_W'(RD_LAT - 1);
               w_ram_regce = 1'b1;
            end
         end
         S_WAIT: begin
            w_cnt = r_cnt - CNT_W'(1);
            if (w_cnt == CNT_W'(0)) w_state = S_RESP;
            else                    w_ram_regce = 1'b1;
         end
         S_RESP: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase

      // ram_dout is valid on the edge that enters RESP.
      if ((w_state == S_RESP) && (r_state != S_RESP)) begin
         w_m0_rvalid = ~r_id;
         w_m1_rvalid = r_id;
         if (r_id) w_m1_rdata = ram_dout;
         else      w_m0_rdata = ram_dout;
      end
      w_busy = (w_state != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_id        <= 1'b0;
         r_we        <= 1'b0;
         r_cnt       <= '0;
         r_m0_gnt    <= 1'b0;
         r_m1_gnt    <= 1'b0;
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
         r_m0_rdata  <= '0;
         r_m1_rdata  <= '0;
         r_ram_addr  <= '0;
         r_ram_din   <= '0;
         r_ram_we    <= 1'b0;
         r_ram_regce <= 1'b0;
         r_busy      <= 1'b0;
`ifndef MEMARB_FIXED_PRIO_EN
         r_last      <= 1'b1;
`endif
      end else begin
         r_state     <= w_state;
         r_id        <= w_id;
         r_we        <= w_we;
         r_cnt       <= w_cnt;
         r_m0_gnt    <= w_m0_gnt;
         r_m1_gnt    <= w_m1_gnt;
         r_m0_rvalid <= w_m0_rvalid;
         r_m1_rvalid <= w_m1_rvalid;
         r_m0_rdata  <= w_m0_rdata;
         r_m1_rdata  <= w_m1_rdata;
         r_ram_addr  <= w_ram_addr;
         r_ram_din   <= w_ram_din;
         r_ram_we    <= w_ram_we;
         r_ram_regce <= w_ram_regce;
         r_busy      <= w_busy;
`ifndef MEMARB_FIXED_PRIO_EN
         r_last      <= w_last;
`endif
      end
   end

   assign m0_gnt    = r_m0_gnt;
   assign m1_gnt    = r_m1_gnt;
   assign m0_rvalid = r_m0_rvalid;
   assign m1_rvalid = r_m1_rvalid;
   assign m0_rdata  = r_m0_rdata;
   assign m1_rdata  = r_m1_rdata;
   assign ram_addr  = r_ram_addr;
   assign ram_din   = r_ram_din;
   assign ram_we    = r_ram_we;
   assign ram_regce = r_ram_regce;
   assign busy      = r_busy;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter with a small RAM model (output register gated by ram_regce).
module tb_rv_mem_arbiter;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              m0_req, m0_we, m1_req, m1_we;
   logic [ADDR_W-1:0] m0_addr, m1_addr;
   logic [DATA_W-1:0] m0_wdata, m1_wdata;
   logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [DATA_W-1:0] m0_rdata, m1_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic              ram_we, ram_regce, busy;
   logic [DATA_W-1:0] ram_dout = '0;

   bit   [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   int n_checks = 0;
   int n_errors = 0;
   int n_m0_gnt = 0;
   int n_m1_gnt = 0;
   int n_m1_rvalid = 0;
   int n_bad_wr = 0;

   always #5 clk = ~clk;

   rv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
      .ram_regce(ram_regce), .ram_dout(ram_dout), .busy(busy)
   );

   // RAM: write on ram_we, output register loads on ram_regce.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      if (ram_regce) ram_dout <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      n_m0_gnt    += int'(m0_gnt);
      n_m1_gnt    += int'(m1_gnt);
      n_m1_rvalid += int'(m1_rvalid);
      n_bad_wr    += int'(ram_we && (ram_addr == 10'h100));
   endtask

   task automatic wait_gnt(output int port, output int cycles);
      port   = -1;
      cycles = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         cycles++;
         if (m0_gnt === 1'b1) begin port = 0; break; end
         if (m1_gnt === 1'b1) begin port = 1; break; end
      end
   endtask

   initial begin
      int port, cycles, exp_port, bad;
      logic [DATA_W-1:0] exp_rd0, exp_rd1;

      rst = 1'b1;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
      tick(); tick();
      check("rst busy", 64'(busy), 64'(0));
      check("rst ram_we", 64'(ram_we), 64'(0));
      check("rst gnt", 64'({m0_gnt, m1_gnt}), 64'(0));
      check("rst rvalid", 64'({m0_rvalid, m1_rvalid}), 64'(0));

      // Test 1: m0 write, then an m1 write used as read data later
      rst = 1'b0; tick();
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'h005; m0_wdata = 32'hDEADBEEF;
      tick();
      check("t1 m0_gnt", 64'(m0_gnt), 64'(1));
      check("t1 m1_gnt", 64'(m1_gnt), 64'(0));
      check("t1 ram_we", 64'(ram_we), 64'(1));
      check("t1 ram_addr", 64'(ram_addr), 64'(10'h005));
      check("t1 ram_din", 64'(ram_din), 64'(32'hDEADBEEF));
      m0_req = 1'b0;
      tick();
      check("t1 busy low", 64'(busy), 64'(0));
      check("t1 ram_we low", 64'(ram_we), 64'(0));
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'h020; m1_wdata = 32'h12345678;
      tick();
      check("t1 m1_gnt", 64'(m1_gnt), 64'(1));
      check("t1 m1 ram_addr", 64'(ram_addr), 64'(10'h020));
      m1_req = 1'b0;
      tick();

      // Test 2: m0 read, RD_LAT=2
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'h005;
      tick();
      check("t2 gnt", 64'(m0_gnt), 64'(1));
      check("t2 regce T+1", 64'(ram_regce), 64'(1));
      check("t2 we", 64'(ram_we), 64'(0));
      m0_req = 1'b0;
      tick();
      check("t2 regce T+2", 64'(ram_regce), 64'(1));
      check("t2 no early rvalid", 64'(m0_rvalid), 64'(0));
      tick();
      check("t2 rvalid", 64'(m0_rvalid), 64'(1));
      check("t2 rdata", 64'(m0_rdata), 64'(32'hDEADBEEF));
      check("t2 m1_rvalid", 64'(m1_rvalid), 64'(0));
      tick();
      check("t2 rvalid pulse", 64'(m0_rvalid), 64'(0));
      check("t2 busy low", 64'(busy), 64'(0));

      // Test 3: simultaneous reads after reset
      rst = 1'b1; tick();
      rst = 1'b0;
      exp_rd0 = '0; exp_rd1 = '0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'h005;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h020;
      for (int k = 0; k < 4; k++) begin
`ifdef MEMARB_FIXED_PRIO_EN
         exp_port = 1;
`else
         exp_port = k % 2;
`endif
         wait_gnt(port, cycles);
         check("t3 grant order", 64'(port), 64'(exp_port));
         tick(); tick();
         if (exp_port == 0) exp_rd0 = 32'hDEADBEEF;
         else               exp_rd1 = 32'h12345678;
         check("t3 rvalid", 64'({m0_rvalid, m1_rvalid}), (exp_port == 0) ? 64'(2'b10) : 64'(2'b01));
         check("t3 m0_rdata", 64'(m0_rdata), 64'(exp_rd0));
         check("t3 m1_rdata", 64'(m1_rdata), 64'(exp_rd1));
      end
      m0_req = 1'b0; m1_req = 1'b0;
      tick();
      check("t3 busy low", 64'(busy), 64'(0));

      // Test 4: m1 back-to-back writes
      n_m0_gnt = 0; n_m1_gnt = 0;
      m1_req = 1'b1; m1_we = 1'b1; m1_wdata = 32'h0000_0013;
      for (int i = 0; i < 16; i++) begin
         m1_addr = ADDR_W'(i);
         wait_gnt(port, cycles);
         check("t4 port", 64'(port), 64'(1));
         check("t4 spacing", 64'(cycles), (i == 0) ? 64'(1) : 64'(2));
         check("t4 ram_addr", 64'(ram_addr), 64'(i));
      end
      m1_req = 1'b0;
      tick();
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem[i] != 32'h13) bad++;
      check("t4 ram contents", 64'(bad), 64'(0));
      check("t4 m1 gnt count", 64'(n_m1_gnt), 64'(16));
      check("t4 m0 idle", 64'(n_m0_gnt), 64'(0));

      // Test 5: reset during WAIT, then write attempted under reset
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h020;
      wait_gnt(port, cycles);
      check("t5 port", 64'(port), 64'(1));
      m1_req = 1'b0;
      tick();
      check("t5 in wait", 64'({busy, ram_regce}), 64'(2'b11));
      rst = 1'b1;
      tick();
      check("t5 busy", 64'(busy), 64'(0));
      check("t5 ctl", 64'({ram_we, ram_regce, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}), 64'(0));
      check("t5 ram_addr", 64'(ram_addr), 64'(0));
      check("t5 m1_rdata", 64'(m1_rdata), 64'(0));
      rst = 1'b0;
      n_m1_rvalid = 0;
      for (int i = 0; i < 6; i++) tick();
      check("t5 no rvalid", 64'(n_m1_rvalid), 64'(0));
      rst = 1'b1;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'h3FF; m1_wdata = 32'hA5A5A5A5;
      tick();
      check("t5 we under rst", 64'(ram_we), 64'(0));
      check("t5 gnt under rst", 64'(m1_gnt), 64'(0));
      m1_req = 1'b0; rst = 1'b0;
      tick();
      check("t5 we after rst", 64'(ram_we), 64'(0));
      check("t5 mem untouched", 64'(mem[10'h3FF]), 64'(0));

      // Test 6: m0 withdraws while m1 is serviced
      n_m0_gnt = 0; n_bad_wr = 0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h020;
      wait_gnt(port, cycles);
      check("t6 port", 64'(port), 64'(1));
      m1_req = 1'b0;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'h100; m0_wdata = 32'h00000BAD;
      tick();
      m0_req = 1'b0;
      tick();
      check("t6 m1 rvalid", 64'(m1_rvalid), 64'(1));
      check("t6 m1 rdata", 64'(m1_rdata), 64'(32'h12345678));
      for (int i = 0; i < 4; i++) tick();
      check("t6 no m0_gnt", 64'(n_m0_gnt), 64'(0));
      check("t6 no ram write", 64'(n_bad_wr), 64'(0));
      check("t6 mem", 64'(mem[10'h100]), 64'(0));
      check("t6 busy", 64'(busy), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
